hex_seg_scan: RTL and testbench
===============================

Name: hex_seg_scan

Overview:
- Downstream consumer of the moving-average block's 16-bit result `m`.
- Shows the result as 4 hex digits on a time-multiplexed, common-anode 7-segment display.
- Holds a shadow copy of the value, loaded only at frame boundaries, so a digit never mixes old and new data.
- Blanks leading zeros on request.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 2.
- CNT_W, 17, width of the scan divider counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; asynchronous, active-low.
- d  input  16  value to display (the `m` output of the averaging stage).
- upd  input  1  load request; a 1-cycle pulse is enough.
- blank_lz  input  1  1 = blank leading zero digits.
- an  output  4  digit enables, active-low; an[0] is the least significant nibble.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).

Behaviour:
- Reset (rstn=0, asynchronous):
  - div_cnt=0, idx=0, shadow=16'h0000, pending=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 for the single cycle where div_cnt==SCAN_DIV-1.
- Digit index:
  - idx (2 bits) increments on tick: 0→1→2→3→0.
  - frame_end = tick && idx==3.
- Update handshake:
  - upd=1 sets pending.
  - On frame_end with pending=1: shadow<=d sampled that cycle, and pending<=0.
  - upd and frame_end in the same cycle: the load still happens using the current d, and pending ends at 0.
  - upd while pending=1: no extra effect; the latest d is captured at load time.
- Output registers, updated every cycle (one-cycle latency from idx/shadow):
  - nib = shadow[4*idx +: 4].
  - seg = hex_enc(nib).
  - an = all ones except bit idx = 0, unless the digit is blanked.
- Blanking:
  - Digit k (k=1..3) is blanked when blank_lz=1 and shadow[15:4*k]==0.
  - A blanked digit drives an=4'b1111 and seg=7'b1111111.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- hex_enc (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Exactly one an bit is low at any time outside reset and blanking; no ghosting cycle where two are low.
- blank_lz is sampled combinationally every cycle; a change takes effect on the next output register update.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - After rstn rises, the first output update drives digit 0 with shadow=0: an=4'b1110, seg=1000000.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF = 7'b1111111, AN_OFF = 4'b1111.
  - The 16 hex segment codes as localparams.
  - A hex_enc function.
- One combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
- Divider, index, shadow/pending logic and output registers stay in hex_seg_scan.

Test Plan:
- Run all directed scenarios with SCAN_DIV=4 for short sim time.
1. Reset, then idle with no upd
   - Required: after the first edge, an=1110, seg=1000000.
   - an walks 1110→1101→1011→0111 every 4 cycles with seg=1000000 throughout.
   - With blank_lz=0, digits 1–3 also show 0.
2. d=16'h12AF, upd pulse
   - Required: shadow changes only at the next frame_end.
   - Per digit: idx0→0001110 (F), idx1→0001000 (A), idx2→0100100 (2), idx3→1111001 (1).
3. blank_lz=1, d=16'h0005 loaded
   - Required: digit 0 shows 0010010.
   - Digits 1–3 have an=1111 and seg=1111111 in their slots.
   - Then d=16'h0000: only digit 0 is lit, showing 1000000.
4. upd pulsed on the exact frame_end cycle with d=16'h00FF, d changed to 16'h1111 the next cycle
   - Required: shadow=16'h00FF and pending=0.
   - No second load occurs at the following frame_end.
5. rstn dropped for 3 cycles while idx=2 and shadow=16'hBEEF
   - Required: an/seg go to off asynchronously.
   - After release: idx=0, shadow=0, first update an=1110, seg=1000000.
6. Continuous check over 1000 random d/upd/blank_lz cycles
   - Assertion: popcount(~an)<=1 on every cycle.
   - Displayed nibble matches a reference model of shadow.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment encoder for the multiplexed display.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [6:0] HEX_0 = 7'b1000000;
    localparam logic [6:0] HEX_1 = 7'b1111001;
    localparam logic [6:0] HEX_2 = 7'b0100100;
    localparam logic [6:0] HEX_3 = 7'b0110000;
    localparam logic [6:0] HEX_4 = 7'b0011001;
    localparam logic [6:0] HEX_5 = 7'b0010010;
    localparam logic [6:0] HEX_6 = 7'b0000010;
    localparam logic [6:0] HEX_7 = 7'b1111000;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0010000;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b0000011;
    localparam logic [6:0] HEX_C = 7'b1000110;
    localparam logic [6:0] HEX_D = 7'b0100001;
    localparam logic [6:0] HEX_E = 7'b0000110;
    localparam logic [6:0] HEX_F = 7'b0001110;

    function automatic logic [6:0] hex_enc(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = HEX_0;
            4'h1:    code = HEX_1;
            4'h2:    code = HEX_2;
            4'h3:    code = HEX_3;
            4'h4:    code = HEX_4;
            4'h5:    code = HEX_5;
            4'h6:    code = HEX_6;
            4'h7:    code = HEX_7;
            4'h8:    code = HEX_8;
            4'h9:    code = HEX_9;
            4'hA:    code = HEX_A;
            4'hB:    code = HEX_B;
            4'hC:    code = HEX_C;
            4'hD:    code = HEX_D;
            4'hE:    code = HEX_E;
            default: code = HEX_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit nibble to active-low 7-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_enc(nib);
    end

endmodule

// File: rtl/hex_seg_scan.sv
// Time-multiplexed 4-digit hex display driver with a frame-synchronous shadow
// register, so a value change never tears across digits within one scan frame.
module hex_seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] d,
    input  logic        upd,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic             pending;
    logic             tick;
    logic             frame_end;
    logic [3:0]       nib;
    logic [6:0]       seg_enc;
    logic             blanked;
    logic [3:0]       an_next;

    assign tick      = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == 2'd3);
    assign dp        = 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // A request arriving on the frame_end cycle itself is honoured immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else if (frame_end && (pending || upd)) begin
            shadow  <= d;
            pending <= 1'b0;
        end else if (upd) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        nib = shadow[{idx, 2'b00} +: 4];
    end

    hex_to_seg u_enc (
        .nib (nib),
        .seg (seg_enc)
    );

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        blanked = 1'b0;
        case (idx)
            2'd1:    blanked = blank_lz && (shadow[15:4]  == 12'h000);
            2'd2:    blanked = blank_lz && (shadow[15:8]  == 8'h00);
            2'd3:    blanked = blank_lz && (shadow[15:12] == 4'h0);
            default: blanked = 1'b0;
        endcase
    end

    always_comb begin
        an_next      = AN_OFF;
        an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (blanked) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_enc;
        end
    end

endmodule

// File: tb/tb_hex_seg_scan.sv
// Self-checking bench for hex_seg_scan with a short scan divider; expected
// display values come from a cycle-count based model of the scan and shadow.
module tb_hex_seg_scan;

    logic        clk;
    logic        rstn;
    logic [15:0] d;
    logic        upd;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int          n_assert;
    int          n_fail;

    int          mcnt;
    logic [15:0] mshadow;
    logic        mpend;
    logic [6:0]  segtab [16];

    hex_seg_scan #(
        .SCAN_DIV (4),
        .CNT_W    (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .d        (d),
        .upd      (upd),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: the digit slot is (cycles since reset / 4) mod 4; a load happens on
    // the last cycle of slot 3 when a request is outstanding or arriving.
    task automatic step(input logic [15:0] dv, input logic uv, input logic bv);
        int         ph;
        int         ix;
        logic       blk;
        logic [3:0] ea;
        logic [6:0] es;
        logic [15:0] hi;
        d        = dv;
        upd      = uv;
        blank_lz = bv;
        ph  = mcnt % 4;
        ix  = (mcnt / 4) % 4;
        hi  = mshadow >> (4 * ix);
        blk = bv && (ix != 0) && (hi == 16'h0000);
        ea  = blk ? 4'hF : ~(4'b0001 << ix);
        es  = blk ? 7'h7F : segtab[hi[3:0]];
        if (ph == 3 && ix == 3 && (mpend || uv)) begin
            mshadow = dv;
            mpend   = 1'b0;
        end else if (uv) begin
            mpend = 1'b1;
        end
        mcnt++;
        @(posedge clk);
        #1;
        check("an", {12'h0, an}, {12'h0, ea});
        check("seg", {9'h0, seg}, {9'h0, es});
        check("dp", {15'h0, dp}, 16'h0001);
        check("one_hot_an", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
    endtask

    task automatic idle(input int n, input logic [15:0] dv, input logic bv);
        for (int i = 0; i < n; i++) step(dv, 1'b0, bv);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rstn     = 1'b1;
        d        = 16'h0000;
        upd      = 1'b0;
        blank_lz = 1'b0;

        // Scenario 1: reset, then idle scan of zeros
        #2 rstn = 1'b0;
        #1;
        check("reset_an", {12'h0, an}, 16'h000F);
        check("reset_seg", {9'h0, seg}, 16'h007F);
        check("reset_dp", {15'h0, dp}, 16'h0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        mcnt    = 0;
        mshadow = 16'h0000;
        mpend   = 1'b0;
        step(16'h0000, 1'b0, 1'b0);
        check("first_an", {12'h0, an}, 16'h000E);
        check("first_seg", {9'h0, seg}, 16'h0040);
        idle(19, 16'h0000, 1'b0);

        // Scenario 2: load 12AF, visible only after the next frame boundary
        step(16'h12AF, 1'b1, 1'b0);
        if ((mcnt % 16) != 0) check("shadow_held", dut.shadow, 16'h0000);
        idle(40, 16'h12AF, 1'b0);

        // Scenario 3: leading-zero blanking of 0005, then 0000
        step(16'h0005, 1'b1, 1'b1);
        idle(36, 16'h0005, 1'b1);
        step(16'h0000, 1'b1, 1'b1);
        idle(36, 16'h0000, 1'b1);

        // Scenario 4: request on the exact frame_end cycle
        while ((mcnt % 16) != 15) step(16'h3333, 1'b0, 1'b0);
        step(16'h00FF, 1'b1, 1'b0);
        check("s4_shadow", dut.shadow, 16'h00FF);
        check("s4_pending", {15'h0, dut.pending}, 16'h0000);
        idle(32, 16'h1111, 1'b0);
        check("s4_no_reload", dut.shadow, 16'h00FF);

        // Scenario 5: asynchronous reset mid-frame with BEEF displayed
        step(16'hBEEF, 1'b1, 1'b0);
        idle(20, 16'hBEEF, 1'b0);
        while (((mcnt / 4) % 4) != 2) step(16'hBEEF, 1'b0, 1'b0);
        check("s5_pre_shadow", dut.shadow, 16'hBEEF);
        rstn = 1'b0;
        #1;
        check("s5_async_an", {12'h0, an}, 16'h000F);
        check("s5_async_seg", {9'h0, seg}, 16'h007F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        mcnt    = 0;
        mshadow = 16'h0000;
        mpend   = 1'b0;
        check("s5_idx", {14'h0, dut.idx}, 16'h0000);
        check("s5_shadow", dut.shadow, 16'h0000);
        step(16'hBEEF, 1'b0, 1'b0);
        check("s5_first_an", {12'h0, an}, 16'h000E);
        check("s5_first_seg", {9'h0, seg}, 16'h0040);

        // Scenario 6: random values, requests and blanking
        begin
            logic [15:0] rd;
            logic        rb;
            rd = 16'h0000;
            rb = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (($urandom % 4) == 0) begin
                    case ($urandom % 4)
                        0:       rd = 16'($urandom % 16);
                        1:       rd = 16'($urandom % 256);
                        default: rd = 16'($urandom);
                    endcase
                end
                if (($urandom % 32) == 0) rb = ~rb;
                step(rd, (($urandom % 8) == 0), rb);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
